// File: rtl/ex1_1_outbuf.sv
// Output buffer for the a*b+c stage: show-ahead FIFO with no upstream backpressure.
// Results arriving while full are dropped and recorded in a sticky flag and a saturating counter.
module ex1_1_outbuf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valido,
  input  logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // A pop frees a slot in the same edge, so a full FIFO can still accept a result.
  always_comb begin
    pop  = out_valid && out_ready;
    push = valido && ((level != FULL) || pop);
    drop = valido && !push;
  end

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; out_data is masked by out_valid so stale words never escape.
  always_ff @(posedge clk) begin
    if (push && rst) mem[wr_ptr] <= data_out;
  end

  // A drop takes priority over a coincident clear, restarting the count at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ex1_1_outbuf.sv
// Self-checking bench for ex1_1_outbuf: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ex1_1_outbuf;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             valido;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       level;
  logic             ovf;
  logic [7:0]       drop_cnt;
  logic             ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_ovf;
  int               m_cnt;
  int               m_pushes;
  int               m_pops;

  ex1_1_outbuf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .valido   (valido),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] m_head();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  // Called at a negedge: drive inputs, advance the model across the posedge, return at the next negedge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
    bit pop_m;
    bit push_m;
    valido = v; data_out = d; out_ready = r; ovf_clr = c;
    pop_m  = (q.size() != 0) && r;
    push_m = v && ((q.size() < DEPTH) || pop_m);
    @(posedge clk);
    if (pop_m) begin
      void'(q.pop_front());
      m_pops++;
    end
    if (push_m) begin
      q.push_back(d);
      m_pushes++;
    end
    if (v && !push_m) begin
      m_ovf = 1'b1;
      m_cnt = c ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
    end else if (c) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    @(negedge clk);
    valido = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; valido = 1'b0; data_out = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    q.delete(); m_ovf = 1'b0; m_cnt = 0; m_pushes = 0; m_pops = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, level, out_data, ovf, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b level=%0d data=%h ovf=%0b cnt=%0d expected all zero",
               out_valid, level, out_data, ovf, drop_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_push();
    step(1'b1, 32'd7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd7 || level !== 3'd1) begin
        n_fail++;
        $display("FAIL single_push[%0d]: valid=%0b data=%0d level=%0d expected 1/7/1",
                 i, out_valid, out_data, level);
      end
      if (i < 3) step(1'b0, '0, 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%0b data=%h level=%0d expected empty", out_valid, out_data, level);
    end
  endtask

  task automatic test_overflow_order();
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_level: level=%0d ovf=%0b expected 4/0", level, ovf);
    end
    step(1'b1, 32'd5, 1'b0, 1'b0);
    n_checks++;
    if (ovf !== 1'b1 || drop_cnt !== 8'd1 || level !== 3'd4) begin
      n_fail++;
      $display("FAIL first_drop: ovf=%0b cnt=%0d level=%0d expected 1/1/4", ovf, drop_cnt, level);
    end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
        n_fail++;
        $display("FAIL pop_order[%0d]: valid=%0b data=%0d expected 1/%0d", i, out_valid, out_data, i);
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL drained: valid=%0b data=%h level=%0d expected 0/0/0", out_valid, out_data, level);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    step(1'b1, 32'd9, 1'b1, 1'b0);
    n_checks++;
    if (level !== 3'd4 || drop_cnt !== 8'(m_cnt) || ovf !== m_ovf) begin
      n_fail++;
      $display("FAIL full_push_pop: level=%0d cnt=%0d ovf=%0b expected 4/%0d/%0b",
               level, drop_cnt, ovf, m_cnt, m_ovf);
    end
    foreach (q[k]) begin
      n_checks++;
      if (out_data !== m_head()) begin
        n_fail++;
        $display("FAIL full_push_pop_seq[%0d]: got %0d expected %0d", k, out_data, m_head());
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (q.size() != 0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL full_push_pop_drain: level=%0d model=%0d expected 0", level, q.size());
    end
  endtask

  task automatic test_saturation_clear();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    n_checks++;
    if (drop_cnt !== 8'd255 || ovf !== 1'b1 || level !== 3'd4) begin
      n_fail++;
      $display("FAIL saturate: cnt=%0d ovf=%0b level=%0d expected 255/1/4", drop_cnt, ovf, level);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (drop_cnt !== 8'd0 || ovf !== 1'b0 || level !== 3'd4 || out_data !== m_head()) begin
      n_fail++;
      $display("FAIL clear_alone: cnt=%0d ovf=%0b level=%0d data=%h expected 0/0/4/%h",
               drop_cnt, ovf, level, out_data, m_head());
    end
    step(1'b1, $urandom, 1'b0, 1'b1);
    n_checks++;
    if (drop_cnt !== 8'd1 || ovf !== 1'b1 || level !== 3'd4) begin
      n_fail++;
      $display("FAIL drop_beats_clear: cnt=%0d ovf=%0b level=%0d expected 1/1/4", drop_cnt, ovf, level);
    end
    while (q.size() != 0) begin
      n_checks++;
      if (out_data !== m_head()) begin
        n_fail++;
        $display("FAIL sat_drain: got %h expected %h", out_data, m_head());
      end
      step(1'b0, '0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0b level=%0d data=%h expected 0/0/0", out_valid, level, out_data);
    end
    q.delete(); m_ovf = 1'b0; m_cnt = 0;
    valido = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL held_reset: valid=%0b level=%0d expected 0/0", out_valid, level);
    end
    rst = 1'b1;
    step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5 || level !== 3'd1) begin
      n_fail++;
      $display("FAIL post_reset_push: valid=%0b data=%h level=%0d expected 1/a5a5a5a5/1",
               out_valid, out_data, level);
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random_traffic();
    int base_pops;
    int attempts;
    int cycles;
    int bad;
    logic v;
    base_pops = m_pops;
    attempts = 0; cycles = 0; bad = 0;
    while (attempts < 20 && cycles < 400) begin
      v = ($urandom_range(0, 2) != 0);
      if (v) attempts++;
      step(v, $urandom, ($urandom_range(0, 3) != 0), 1'b0);
      cycles++;
      n_checks++;
      if (out_data !== m_head() || level !== 3'(q.size()) || out_valid !== (q.size() != 0)
          || level > 3'd4 || ovf !== m_ovf || drop_cnt !== 8'(m_cnt)) begin
        n_fail++; bad++;
        if (bad < 5)
          $display("FAIL random[%0d]: data=%h level=%0d ovf=%0b cnt=%0d expected %h/%0d/%0b/%0d",
                   cycles, out_data, level, ovf, drop_cnt, m_head(), q.size(), m_ovf, m_cnt);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (out_data !== m_head() || level !== 3'(q.size())) begin
        n_fail++;
        $display("FAIL random_drain[%0d]: data=%h level=%0d expected %h/%0d",
                 i, out_data, level, m_head(), q.size());
      end
    end
    n_checks++;
    if (attempts != 20 || (m_pops - base_pops) + 1 < 4 * DEPTH) begin
      n_fail++;
      $display("FAIL random_coverage: pushes=%0d pops=%0d expected 20 pushes and >=%0d pops",
               attempts, m_pops - base_pops, 4 * DEPTH - 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overflow_order();
    test_full_push_pop();
    test_saturation_clear();
    test_async_reset();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex1_1_outbuf.md
EX1_1_OUTBUF -- requirements
Module: ex1_1_outbuf

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the FIFO entry count; it must be a power of two and at least 2.
REQ-002 The block SHALL have a parameter WIDTH, default 32, giving the data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port valido, input, 1, upstream result strobe from the a*b+c stage; there is no backpressure to that stage.
REQ-006 The block SHALL have port data_out, input, WIDTH, the upstream result, sampled only when valido=1.
REQ-007 The block SHALL have port out_valid, output, 1, set when the FIFO is non-empty.
REQ-008 The block SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-009 The block SHALL have port out_data, output, WIDTH, the head entry.
REQ-010 The block SHALL have port level, output, $clog2(DEPTH)+1, the current occupancy, 0..DEPTH.
REQ-011 The block SHALL have port ovf, output, 1, a sticky flag meaning a result was dropped.
REQ-012 The block SHALL have port drop_cnt, output, 8, the count of dropped results, saturating.
REQ-013 The block SHALL have port ovf_clr, input, 1, a synchronous clear of ovf and drop_cnt.

Function
REQ-014 A push SHALL occur at an edge when valido=1 and either level<DEPTH, or level==DEPTH with a pop at the same edge.
REQ-015 A pop SHALL occur at an edge when out_valid=1 and out_ready=1.
REQ-016 out_valid SHALL equal (level!=0), driven from registered state only, with no combinational path from valido or out_ready.
REQ-017 out_data SHALL present the oldest unpopped entry (show-ahead), and SHALL be 0 when out_valid=0.
REQ-018 Latency: a result pushed at edge N SHALL appear on out_data with out_valid=1 in the cycle after edge N, provided the FIFO was empty; there is no same-cycle pass-through.
REQ-019 Push and pop at the same edge SHALL leave level unchanged and preserve FIFO order.
REQ-020 If valido=1 while level==0, the pop condition is false by REQ-016, so only the push occurs.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; level SHALL use the extra MSB so that full and empty are distinguished.
REQ-022 If valido=1 at level==DEPTH with no pop, the result SHALL be discarded, ovf set to 1, and drop_cnt incremented.
REQ-023 drop_cnt SHALL saturate at 255.
REQ-024 Storage, pointers and level SHALL be unaffected by a drop.
REQ-025 ovf_clr=1 SHALL clear ovf to 0 and drop_cnt to 0 at the next edge.
REQ-026 If a drop coincides with ovf_clr, the drop SHALL win: ovf becomes 1 and drop_cnt becomes 1.
REQ-027 ovf_clr SHALL NOT affect FIFO contents, pointers or level.
REQ-028 Data SHALL pass bit-exact; the block SHALL perform no arithmetic on the payload.

Reset
REQ-029 While rst=0, asynchronously and independent of clk: pointers SHALL be 0, level 0, out_valid 0, out_data 0, ovf 0, and drop_cnt 0.
REQ-030 Storage contents need not be reset, since out_data is masked per REQ-017.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; no pop or push SHALL take effect while rst=0.
REQ-032 The first edge after rst rises SHALL behave as a normal edge, so a push is accepted if valido=1.

Verification
REQ-033 Scenario: reset, then valido=1 for one cycle with data_out=7 and out_ready=0 -> next cycle out_valid=1, out_data=7, level=1; hold for 3 cycles -> values unchanged.
REQ-034 Scenario: DEPTH=4, push 1,2,3,4 with out_ready=0 -> level=4; then push 5 -> ovf=1, drop_cnt=1, level=4; then out_ready=1 -> pops 1,2,3,4 in order, then out_valid=0 and out_data=0.
REQ-035 Scenario: level=4 with head 1, valido=1 with data 9 and out_ready=1 at the same edge -> no drop, level stays 4, sequence 2,3,4,9 follows.
REQ-036 Scenario: 300 pushes into a full FIFO with out_ready=0 -> drop_cnt=255, ovf=1; then ovf_clr=1 alone -> both 0; then ovf_clr=1 together with a drop -> ovf=1, drop_cnt=1.
REQ-037 Scenario: 3 entries buffered, rst low asynchronously between edges -> out_valid, level and out_data go to 0 immediately; after release, a push of 0xA5A5A5A5 is popped as the first word.
REQ-038 Scenario: 20 random-gap pushes with random out_ready -> scoreboard order and values match, level never exceeds 4, and pointer wrap is exercised at least 4 times.
